// File: rtl/ed25519_pkg.sv
// ed25519_pkg: field constants, element type and sequencer states for the Ed25519 datapath
package ed25519_pkg;
  typedef logic [254:0] fe_t;
  localparam fe_t P_MOD = fe_t'({255{1'b1}} - 255'd18);
  localparam fe_t ED_D = fe_t'(256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3);
  typedef enum logic [2:0] {IDLE, LOAD, MUL_XY, MUL_D, WRITE, DONE, ERR} state_t;
endpackage

// File: rtl/mod_addsub.sv
// mod_addsub: combinational add or subtract modulo p for reduced field elements
module mod_addsub
  import ed25519_pkg::*;
(
  input  fe_t  a,
  input  fe_t  b,
  input  logic sub_sel,
  output fe_t  r
);
  logic [255:0] w_sum, w_diff;
  fe_t          w_sum_red, w_diff_fix;
  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_sum_red  = w_sum[254:0] - P_MOD;
  assign w_diff     = {1'b0, a} - {1'b0, b};
  assign w_diff_fix = w_diff[254:0] + P_MOD;
  assign r = sub_sel ? (w_diff[255] ? w_diff_fix : w_diff[254:0])
                     : (w_sum >= {1'b0, P_MOD} ? w_sum_red : w_sum[254:0]);
endmodule

// File: rtl/lut_precalc_ctrl.sv
// lut_precalc_ctrl: loads affine P into the LUT entry and rewrites it in precalc form (y-x, y+x, 1, x*y*d)
module lut_precalc_ctrl
  import ed25519_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  fe_t  x_in,
  input  fe_t  y_in,
  input  fe_t  lut_x,
  input  fe_t  lut_y,
  output fe_t  lut_x_wdata,
  output fe_t  lut_y_wdata,
  output fe_t  lut_z_wdata,
  output fe_t  lut_t_wdata,
  output logic lut_x_we,
  output logic lut_y_we,
  output logic lut_z_we,
  output logic lut_t_we,
  output logic mul_req,
  output fe_t  mul_a,
  output fe_t  mul_b,
  input  logic mul_ack,
  input  fe_t  mul_res,
  output logic busy,
  output logic done,
  output logic err
);
  state_t           r_state;
  logic             r_req, r_busy, r_done, r_err;
  logic [CNT_W-1:0] r_cnt;
  fe_t              r_a, r_b, r_t, r_xw, r_yw, r_zw, r_tw;
  fe_t              w_sub, w_add;

  mod_addsub u_sub (.a(lut_y), .b(lut_x), .sub_sel(1'b1), .r(w_sub));
  mod_addsub u_add (.a(lut_y), .b(lut_x), .sub_sel(1'b0), .r(w_add));

  assign lut_x_we    = r_state == LOAD || r_state == WRITE;
  assign lut_y_we    = lut_x_we;
  assign lut_t_we    = lut_x_we;
  assign lut_z_we    = r_state == LOAD;
  assign lut_x_wdata = r_xw;
  assign lut_y_wdata = r_yw;
  assign lut_z_wdata = r_zw;
  assign lut_t_wdata = r_tw;
  assign mul_req     = r_req;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

  // sequencer: write data is staged one cycle ahead of its write enable; the first MUL cycle loads operands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_t     <= '0;
      r_xw    <= '0;
      r_yw    <= '0;
      r_zw    <= '0;
      r_tw    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= LOAD;
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_xw    <= x_in;
          r_yw    <= y_in;
          r_zw    <= fe_t'(1);
          r_tw    <= '0;
        end
        LOAD: r_state <= MUL_XY;
        MUL_XY, MUL_D: if (!r_req) begin
          r_req <= 1'b1;
          r_cnt <= '0;
          r_a   <= r_state == MUL_XY ? lut_x : r_t;
          r_b   <= r_state == MUL_XY ? lut_y : ED_D;
        end else if (mul_ack) begin
          r_req   <= 1'b0;
          r_t     <= mul_res;
          r_state <= r_state == MUL_XY ? MUL_D : WRITE;
          if (r_state == MUL_D) begin
            r_xw <= w_sub;
            r_yw <= w_add;
            r_tw <= mul_res;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          r_req   <= 1'b0;
          r_err   <= 1'b1;
          r_state <= ERR;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        WRITE: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        ERR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_precalc_ctrl.sv
// tb_lut_precalc_ctrl: vector table plus corner sequences against an arithmetic reference of the precalc rules
module tb_lut_precalc_ctrl;
  typedef logic [254:0] fe_t;
  localparam fe_t P_REF = fe_t'({255{1'b1}} - 255'd18);
  localparam fe_t D_REF = fe_t'(256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3);

  typedef struct {
    fe_t x;
    fe_t y;
    int  lat;
    fe_t ex;
    fe_t ey;
    fe_t et;
  } vec_t;

  logic clk = 0, rst = 1, start = 0, mul_ack_m = 0, spur_ack = 0;
  fe_t  x_in = '0, y_in = '0, lx = '0, ly = '0, lz = '0, lt = '0, mul_res = '0;
  fe_t  xw, yw, zw, tw, mul_a, mul_b;
  logic xwe, ywe, zwe, twe, mul_req, busy, done, err;

  int   n_pass = 0, n_tot = 0, mul_lat = 4, done_k, req_hi, n_load, n_write;
  bit   no_ack = 0;
  logic err_load;
  fe_t  c_lx, c_ly, c_lz, c_lt, c_wx, c_wy, c_wt;
  vec_t tbl[9];

  lut_precalc_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .lut_x(lx), .lut_y(ly),
    .lut_x_wdata(xw), .lut_y_wdata(yw), .lut_z_wdata(zw), .lut_t_wdata(tw),
    .lut_x_we(xwe), .lut_y_we(ywe), .lut_z_we(zwe), .lut_t_we(twe),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack_m | spur_ack), .mul_res(mul_res),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xwe) lx <= xw;
    if (ywe) ly <= yw;
    if (zwe) lz <= zw;
    if (twe) lt <= tw;
  end

  function automatic fe_t fmul(fe_t a, fe_t b);
    logic [511:0] t;
    t = ({257'd0, a} * {257'd0, b}) % {257'd0, P_REF};
    return t[254:0];
  endfunction

  function automatic fe_t fadd(fe_t a, fe_t b);
    logic [255:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, P_REF};
    return s[254:0];
  endfunction

  function automatic fe_t fsub(fe_t a, fe_t b);
    logic [255:0] s;
    s = ({1'b0, a} + {1'b0, P_REF} - {1'b0, b}) % {1'b0, P_REF};
    return s[254:0];
  endfunction

  function automatic fe_t rnd_fe();
    logic [255:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r = r % {1'b0, P_REF};
    return r[254:0];
  endfunction

  // multiplier model: acks on the mul_lat-th cycle that mul_req is seen high
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mul_req && !no_ack) begin
        repeat (mul_lat - 1) begin
          @(posedge clk);
          #1;
        end
        mul_ack_m = 1;
        mul_res   = fmul(mul_a, mul_b);
        @(posedge clk);
        #1;
        mul_ack_m = 0;
      end
    end
  end

  task automatic chk(string nm, fe_t act, fe_t exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic run_op(fe_t x, fe_t y, bit spur, int rst_at);
    x_in  = x;
    y_in  = y;
    start = 1;
    @(posedge clk);
    #1;
    start    = 0;
    x_in     = rnd_fe();
    y_in     = rnd_fe();
    done_k   = -1;
    req_hi   = 0;
    n_load   = 0;
    n_write  = 0;
    err_load = err;
    for (int k = 1; k <= 200; k++) begin
      spur_ack = spur && k == 1;
      start    = spur && k == 3;
      if (rst_at == k) begin
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        chk("rst_busy", fe_t'(busy), fe_t'(0));
        chk("rst_req", fe_t'(mul_req), fe_t'(0));
        break;
      end
      if (xwe && ywe && zwe && twe) begin
        n_load++;
        c_lx = xw; c_ly = yw; c_lz = zw; c_lt = tw;
      end
      if (xwe && ywe && twe && !zwe) begin
        n_write++;
        c_wx = xw; c_wy = yw; c_wt = tw;
      end
      if (mul_req) req_hi++;
      if (done) begin
        done_k = k;
        break;
      end
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    spur_ack = 0;
    start    = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(vec_t v, bit spur, string tag);
    mul_lat = v.lat;
    run_op(v.x, v.y, spur, 0);
    chk({tag, "_load_x"}, c_lx, v.x);
    chk({tag, "_load_y"}, c_ly, v.y);
    chk({tag, "_load_z"}, c_lz, fe_t'(1));
    chk({tag, "_load_t"}, c_lt, fe_t'(0));
    chk({tag, "_wr_x"}, c_wx, v.ex);
    chk({tag, "_wr_y"}, c_wy, v.ey);
    chk({tag, "_wr_t"}, c_wt, v.et);
    chk({tag, "_lut_z"}, lz, fe_t'(1));
    chk({tag, "_writes"}, fe_t'(n_load * 10 + n_write), fe_t'(11));
    chk({tag, "_latency"}, fe_t'(done_k), fe_t'(2 * v.lat + 5));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", fe_t'({busy, done, err, mul_req, xwe, ywe, zwe, twe}), fe_t'(0));
    chk("rst_data", xw | yw | zw | tw | mul_a | mul_b, fe_t'(0));
    rst = 0;
    @(posedge clk);
    #1;

    tbl[0] = '{x: fe_t'(5), y: fe_t'(3), lat: 4, ex: P_REF - fe_t'(2), ey: fe_t'(8), et: fmul(fe_t'(15), D_REF)};
    tbl[1] = '{x: P_REF - fe_t'(1), y: fe_t'(1), lat: 3, ex: fe_t'(2), ey: fe_t'(0), et: P_REF - D_REF};
    tbl[2] = '{x: fe_t'(0), y: fe_t'(1), lat: 1, ex: fe_t'(1), ey: fe_t'(1), et: fe_t'(0)};
    for (int i = 3; i < 9; i++) begin
      tbl[i].x   = rnd_fe();
      tbl[i].y   = rnd_fe();
      tbl[i].lat = int'($urandom_range(1, 6));
      tbl[i].ex  = fsub(tbl[i].y, tbl[i].x);
      tbl[i].ey  = fadd(tbl[i].y, tbl[i].x);
      tbl[i].et  = fmul(fmul(tbl[i].x, tbl[i].y), D_REF);
    end

    for (int i = 0; i < 9; i++) apply_vec(tbl[i], 0, $sformatf("vec%0d", i));

    apply_vec(tbl[0], 1, "spurious");

    no_ack = 1;
    run_op(fe_t'(7), fe_t'(9), 0, 0);
    chk("wd_req_cycles", fe_t'(req_hi), fe_t'(16));
    chk("wd_no_done", fe_t'(done_k == -1), fe_t'(1));
    chk("wd_err", fe_t'(err), fe_t'(1));
    chk("wd_writes", fe_t'(n_load * 10 + n_write), fe_t'(10));
    no_ack = 0;
    apply_vec(tbl[2], 0, "after_wd");
    chk("err_cleared", fe_t'(err_load), fe_t'(0));

    mul_lat = 4;
    run_op(tbl[0].x, tbl[0].y, 0, 9);
    repeat (10) @(posedge clk);
    #1;
    apply_vec(tbl[3], 0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/lut_precalc_ctrl.md
Name: lut_precalc_ctrl

Overview:
Sequencer that fills the point LUT register file for Ed25519 scalar multiplication: loads affine input P=(x,y), then converts the entry in place to precalc form (A2=y-x, B2=y+x, Z=1, Td=x*y*d, all mod p=2^255-19). Sits between the top-level input handshake, the LUT file's four write ports, and the shared modular multiplier, which it drives through a req/ack interface. Add/sub mod p is done internally; multiplications go to the shared multiplier.

Parameters:
TIMEOUT_CYC, 1024, max cycles to wait for a single mul_ack before aborting to ERR
CNT_W, 11, width of watchdog counter (must hold TIMEOUT_CYC)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse, begin load+precalc; sampled only in IDLE
x_in  input  255  affine x of P, reduced (< p), sampled with start
y_in  input  255  affine y of P, reduced (< p), sampled with start
lut_x  input  255  LUT X read-back
lut_y  input  255  LUT Y read-back
lut_x_wdata  output  255  LUT X write data
lut_y_wdata  output  255  LUT Y write data
lut_z_wdata  output  255  LUT Z write data
lut_t_wdata  output  255  LUT T write data
lut_x_we, lut_y_we, lut_z_we, lut_t_we  output  1 each  LUT write enables
mul_req  output  1  multiplier request, level, held until mul_ack
mul_a  output  255  multiplier operand A, stable while mul_req
mul_b  output  255  multiplier operand B, stable while mul_req
mul_ack  input  1  one-cycle pulse, mul_res valid
mul_res  input  255  a*b mod p
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when LUT holds precalc form
err  output  1  sticky watchdog flag, cleared by rst or next accepted start

Behaviour:
- Reset: state=IDLE; all *_we, mul_req, busy, done, err = 0; all wdata, mul_a, mul_b, internal t_reg = 0. Reset mid-operation aborts immediately, mul_req drops the next edge; LUT contents unaffected by this block (the LUT file has its own reset).
- States: IDLE, LOAD, MUL_XY, MUL_D, WRITE, DONE, ERR.
- IDLE: start=1 -> LOAD, err cleared. start in any other state ignored.
- LOAD (1 cycle): lut_x_wdata=x_in, lut_y_wdata=y_in, lut_z_wdata=1, lut_t_wdata=0, all four we=1 -> MUL_XY.
- MUL_XY: mul_req=1, mul_a=lut_x, mul_b=lut_y. On mul_ack: t_reg<=mul_res -> MUL_D.
- MUL_D: mul_req=1, mul_a=t_reg, mul_b=ED_D. On mul_ack: t_reg<=mul_res -> WRITE.
- mul_req deasserts the cycle after mul_ack (registered); new request reasserts that cycle in the next MUL state, so mul_req shows a one-cycle low gap between the two requests. mul_ack while mul_req=0 ignored.
- WRITE (1 cycle): lut_x_wdata=(lut_y-lut_x) mod p, lut_y_wdata=(lut_y+lut_x) mod p, lut_t_wdata=t_reg; x/y/t we=1, z_we=0 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Mod arithmetic: add = s=a+b (256b); if s>=p then s-p. Sub = a-b; if borrow then +p. Operands assumed <p; results always <p.
- Watchdog: counter resets on entry to each MUL state, increments each cycle mul_req=1 without ack; reaching TIMEOUT_CYC -> ERR (mul_req=0, err=1), ERR -> IDLE next cycle. LUT left partially written.
- Latency start->done with mul latency L: 1 (LOAD) + (L+1) + (L+1) + 1 (WRITE) + 1 (DONE) cycles.
- we outputs are combinational from registered state; wdata registered or state-decoded, but must be valid the same cycle as we.

Decomposition:
- Shared package ed25519_pkg: P_MOD (2^255-19), ED_D (0x52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3), state enum, 255-bit field-element type.
- One sub-module: mod_addsub (a, b, sub_sel -> r mod p), combinational, reused elsewhere in the datapath.

Test Plan:
- x=5, y=3, mul model L=4 -> LOAD writes (5,3,1,0); WRITE: X=p-2, Y=8, T=15*ED_D mod p; done exactly 13 cycles after start.
- x=p-1, y=1 -> Y=0 (add wrap), X=2, T=(p-1)*ED_D mod p = p-ED_D.
- x=0, y=1 (neutral point) -> X=1, Y=1, Z=1, T=0.
- mul model never acks, TIMEOUT_CYC=16 -> ERR after 16 cycles of mul_req, err=1, done never pulses; next start clears err.
- rst asserted mid MUL_D -> next cycle busy=0, mul_req=0; fresh start completes normally.
- start pulsed again while busy and spurious mul_ack in LOAD -> both ignored, result identical to clean run.
